input_flit_fifo: RTL and testbench

//   Per-port input buffer feeding the LBDR routing stage. Stores incoming flits in a

---
 rtl/input_flit_fifo_if.sv | 39 +++
 rtl/input_flit_fifo.sv | 132 +++++++++++++
 tb/tb_input_flit_fifo.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/input_flit_fifo_if.sv
// Flit-side bus of the per-port input buffer: link write port plus the
// allocator read port and the head-flit view that LBDR samples.
interface input_flit_fifo_if #(
    parameter int DATA_WIDTH = 32
);
    // Handshake: wr_en acts as valid on the write side, with ready = !full || rd_en;
    // a flit moves only when both are high at a posedge. On the read side rd_en
    // pops the head only when !empty, and the next flit shows up one cycle later.
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] flit_in;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] flit_out;
    logic [2:0]            flit_id;
    logic [3:0]            dst_addr;
    logic                  empty;
    logic                  full;

    modport master (
        output wr_en,
        output flit_in,
        output rd_en,
        input  flit_out,
        input  flit_id,
        input  dst_addr,
        input  empty,
        input  full
    );

    modport slave (
        input  wr_en,
        input  flit_in,
        input  rd_en,
        output flit_out,
        output flit_id,
        output dst_addr,
        output empty,
        output full
    );
endinterface

// File: rtl/input_flit_fifo.sv
// Per-port first-word-fall-through flit buffer with write-side packet framing check.
// Optional feature macro FIFO_CREDIT_EN adds credit_out / credit_init for credit flow control.
module input_flit_fifo #(
    parameter int         DATA_WIDTH = 32,
    parameter int         DEPTH      = 4,
    parameter logic [2:0] HEADER     = 3'b001,
    parameter logic [2:0] PAYLOAD    = 3'b010,
    parameter logic [2:0] TAIL       = 3'b100
) (
    input  logic                 clk,
    input  logic                 rst,
    input_flit_fifo_if.slave     bus,
    output logic                 frame_err,
    output logic                 frame_state
`ifdef FIFO_CREDIT_EN
    ,
    output logic                 credit_out,
    output logic [2:0]           credit_init
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {
        IDLE   = 1'b0,
        IN_PKT = 1'b1
    } frame_state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0]           wptr;
    logic [AW:0]           rptr;
    logic                  addr_eq;
    logic                  is_empty;
    logic                  is_full;
    logic                  push_ok;
    logic                  pop_ok;
    logic [2:0]            in_id;

    frame_state_e          state_q;
    frame_state_e          state_d;
    logic                  err_set;

    // Extra pointer bit distinguishes full from empty when the slot addresses match.
    assign addr_eq  = (wptr[AW-1:0] == rptr[AW-1:0]);
    assign is_empty = (wptr == rptr);
    assign is_full  = addr_eq && (wptr[AW] != rptr[AW]);

    // A pop frees the head slot in the same edge, so a full buffer still takes a push.
    assign push_ok = bus.wr_en && (!is_full || bus.rd_en);
    assign pop_ok  = bus.rd_en && !is_empty;

    assign in_id = bus.flit_in[DATA_WIDTH-1 -: 3];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) begin
                wptr <= wptr + 1'b1;
            end
            if (pop_ok) begin
                rptr <= rptr + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; consumers gate on empty.
    always_ff @(posedge clk) begin
        if (rst && push_ok) begin
            mem[wptr[AW-1:0]] <= bus.flit_in;
        end
    end

    assign bus.flit_out = mem[rptr[AW-1:0]];
    assign bus.flit_id  = bus.flit_out[DATA_WIDTH-1 -: 3];
    assign bus.dst_addr = bus.flit_out[DATA_WIDTH-4 -: 4];
    assign bus.empty    = is_empty;
    assign bus.full     = is_full;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= IDLE;
            frame_err <= 1'b0;
        end else begin
            state_q   <= state_d;
            frame_err <= frame_err | err_set;
        end
    end

    // Framing only tracks flits that were actually accepted; violating flits are still stored.
    always_comb begin
        state_d = state_q;
        err_set = 1'b0;
        if (push_ok) begin
            case (state_q)
                IDLE: begin
                    if (in_id == HEADER) begin
                        state_d = IN_PKT;
                    end else begin
                        err_set = 1'b1;
                    end
                end
                IN_PKT: begin
                    if (in_id == TAIL) begin
                        state_d = IDLE;
                    end else if (in_id != PAYLOAD) begin
                        err_set = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    assign frame_state = state_q;

`ifdef FIFO_CREDIT_EN
    always_ff @(posedge clk) begin
        if (!rst) begin
            credit_out <= 1'b0;
        end else begin
            credit_out <= pop_ok;
        end
    end

    assign credit_init = 3'(DEPTH);
`endif

endmodule

// File: tb/tb_input_flit_fifo.sv
// Directed bench for input_flit_fifo: reset, FWFT ordering, full/wrap, simultaneous
// push/pop, framing errors and, when FIFO_CREDIT_EN is defined, credit returns.
module tb_input_flit_fifo;

    localparam int         W       = 32;
    localparam int         DEPTH   = 4;
    localparam logic [2:0] HEADER  = 3'b001;
    localparam logic [2:0] PAYLOAD = 3'b010;
    localparam logic [2:0] TAIL    = 3'b100;

    logic clk;
    logic rst;
    logic frame_err;
    logic frame_state;
`ifdef FIFO_CREDIT_EN
    logic       credit_out;
    logic [2:0] credit_init;
    logic       exp_credit;
`endif

    int n_checks;
    int n_bad;
    logic [W-1:0] exp_q[$];

    input_flit_fifo_if #(.DATA_WIDTH(W)) bus_if ();

    input_flit_fifo #(
        .DATA_WIDTH(W),
        .DEPTH     (DEPTH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus_if.slave),
        .frame_err  (frame_err),
        .frame_state(frame_state)
`ifdef FIFO_CREDIT_EN
        ,
        .credit_out (credit_out),
        .credit_init(credit_init)
`endif
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [2:0] id, input logic [3:0] dst,
                                        input logic [24:0] pl);
        return {id, dst, pl};
    endfunction

    task automatic check_fifo(input string tag);
        check({tag, ".empty"}, W'(bus_if.empty), W'(exp_q.size() == 0));
        check({tag, ".full"},  W'(bus_if.full),  W'(exp_q.size() == DEPTH));
        if (exp_q.size() > 0) begin
            check({tag, ".head"}, bus_if.flit_out, exp_q[0]);
        end
`ifdef FIFO_CREDIT_EN
        check({tag, ".credit"}, W'(credit_out), W'(exp_credit));
`endif
    endtask

    // driver: one clock of wr/rd activity, then update the expected queue
    task automatic step(input string tag, input logic wr, input logic [W-1:0] d, input logic rd);
        logic do_pop;
        logic do_push;
        do_pop  = rd && (exp_q.size() > 0);
        do_push = wr && ((exp_q.size() < DEPTH) || rd);
        bus_if.wr_en   = wr;
        bus_if.flit_in = d;
        bus_if.rd_en   = rd;
        @(posedge clk);
        #1;
        bus_if.wr_en = 1'b0;
        bus_if.rd_en = 1'b0;
        if (do_pop) begin
            void'(exp_q.pop_front());
        end
        if (do_push) begin
            exp_q.push_back(d);
        end
`ifdef FIFO_CREDIT_EN
        exp_credit = do_pop;
`endif
        check_fifo(tag);
    endtask

    task automatic push(input string tag, input logic [W-1:0] d);
        step(tag, 1'b1, d, 1'b0);
    endtask

    task automatic pop(input string tag);
        step(tag, 1'b0, '0, 1'b1);
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, '0, 1'b0);
    endtask

    // reset held for two edges with a write pending, which must be ignored
    task automatic do_reset(input string tag);
        rst            = 1'b0;
        bus_if.wr_en   = 1'b1;
        bus_if.flit_in = mk(HEADER, 4'h5, 25'h1);
        bus_if.rd_en   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst          = 1'b1;
        bus_if.wr_en = 1'b0;
        exp_q.delete();
`ifdef FIFO_CREDIT_EN
        exp_credit = 1'b0;
`endif
        check_fifo(tag);
        check({tag, ".frame_err"}, W'(frame_err), '0);
        check({tag, ".state"}, W'(frame_state), '0);
    endtask

    initial begin
        n_checks       = 0;
        n_bad          = 0;
        rst            = 1'b0;
        bus_if.wr_en   = 1'b0;
        bus_if.rd_en   = 1'b0;
        bus_if.flit_in = '0;
`ifdef FIFO_CREDIT_EN
        exp_credit = 1'b0;
`endif

        // 1: reset, nothing gets stored
        do_reset("rst");
        idle("rst_idle");
`ifdef FIFO_CREDIT_EN
        check("credit_init", W'(credit_init), W'(4));
`endif

        // 2: FWFT latency and ordering
        push("fwft_h", mk(HEADER, 4'hA, 25'h00_1234));
        check("fwft.id",  W'(bus_if.flit_id),  W'(HEADER));
        check("fwft.dst", W'(bus_if.dst_addr), W'(4'hA));
        push("fwft_p", mk(PAYLOAD, 4'h0, 25'h0A_BCDE));
        push("fwft_t", mk(TAIL, 4'h0, 25'h1F_FFFF));
        check("fwft.id_after3", W'(bus_if.flit_id), W'(HEADER));
        pop("fwft_pop1");
        check("fwft.id_pop1", W'(bus_if.flit_id), W'(PAYLOAD));
        pop("fwft_pop2");
        check("fwft.id_pop2", W'(bus_if.flit_id), W'(TAIL));
        pop("fwft_pop3");
        check("fwft.empty3", W'(bus_if.empty), W'(1));
        pop("fwft_pop_empty");
        check("fwft.frame_err", W'(frame_err), '0);

        // 3: fill, drop on full, drain; three rounds walk the pointers past the wrap
        for (int r = 0; r < 3; r++) begin
            push("wrap_h", mk(HEADER,  4'(r + 1), 25'(32'h100 + r)));
            push("wrap_p", mk(PAYLOAD, 4'h0,      25'(32'h200 + r)));
            push("wrap_p", mk(PAYLOAD, 4'h0,      25'(32'h300 + r)));
            push("wrap_t", mk(TAIL,    4'h0,      25'(32'h400 + r)));
            check("wrap.full", W'(bus_if.full), W'(1));
            push("wrap_drop", mk(HEADER, 4'hF, 25'h1_DEAD));
            check("wrap.drop_head", W'(bus_if.dst_addr), W'(4'(r + 1)));
            check("wrap.drop_err", W'(frame_err), '0);
            for (int k = 0; k < 4; k++) pop("wrap_pop");
            check("wrap.empty", W'(bus_if.empty), W'(1));
            check("wrap.state", W'(frame_state), '0);
        end

        // 4: simultaneous push+pop when full, then when empty
        push("sim_h", mk(HEADER,  4'h3, 25'h11));
        push("sim_p", mk(PAYLOAD, 4'h0, 25'h22));
        push("sim_p", mk(PAYLOAD, 4'h0, 25'h33));
        push("sim_p", mk(PAYLOAD, 4'h0, 25'h44));
        step("sim_full_rw", 1'b1, mk(TAIL, 4'h0, 25'h55), 1'b1);
        check("sim.full_kept", W'(bus_if.full), W'(1));
        check("sim.head_adv",  bus_if.flit_out, mk(PAYLOAD, 4'h0, 25'h22));
        for (int k = 0; k < 4; k++) pop("sim_drain");
        check("sim.tail_last", W'(bus_if.empty), W'(1));
        step("sim_empty_rw", 1'b1, mk(HEADER, 4'h7, 25'h66), 1'b1);
        check("sim.empty_fall", W'(bus_if.empty), W'(0));
        check("sim.dst7", W'(bus_if.dst_addr), W'(4'h7));
        push("sim_t", mk(TAIL, 4'h0, 25'h77));
        pop("sim_pop");
        pop("sim_pop");
        check("sim.frame_err", W'(frame_err), '0);

        // 5: framing violations are sticky and the flit is still stored
        push("frm_p_idle", mk(PAYLOAD, 4'h0, 25'h88));
        check("frm.payload_idle", W'(frame_err), W'(1));
        pop("frm_pop");
        idle("frm_idle");
        idle("frm_idle");
        check("frm.sticky", W'(frame_err), W'(1));
        do_reset("frm_rst1");
        push("frm_h1", mk(HEADER, 4'h1, 25'h91));
        check("frm.h1_ok", W'(frame_err), '0);
        push("frm_h2", mk(HEADER, 4'h2, 25'h92));
        check("frm.hh", W'(frame_err), W'(1));
        check("frm.hh_state", W'(frame_state), W'(1));
        // reset mid-packet with flits buffered
        do_reset("frm_rst2");
        push("frm_t_idle", mk(TAIL, 4'h0, 25'h93));
        check("frm.tail_idle", W'(frame_err), W'(1));
        do_reset("frm_rst3");
        push("frm_h3", mk(HEADER, 4'h4, 25'h94));
        push("frm_bad", mk(3'b111, 4'h0, 25'h95));
        check("frm.bad_id", W'(frame_err), W'(1));
        check("frm.bad_state", W'(frame_state), W'(1));

        // 6: credit pulses follow each accepted pop by one cycle
        do_reset("crd_rst");
        push("crd_h", mk(HEADER,  4'h9, 25'hA1));
        push("crd_p", mk(PAYLOAD, 4'h0, 25'hA2));
        push("crd_t", mk(TAIL,    4'h0, 25'hA3));
        pop("crd_pop1");
        pop("crd_pop2");
        idle("crd_gap");
        pop("crd_pop3");
        idle("crd_after");
        pop("crd_pop_empty");
`ifdef FIFO_CREDIT_EN
        push("crd_h2", mk(HEADER, 4'h9, 25'hA4));
        bus_if.rd_en = 1'b1;
        @(posedge clk);
        #1;
        bus_if.rd_en = 1'b0;
        void'(exp_q.pop_front());
        check("crd.pulse", W'(credit_out), W'(1));
        do_reset("crd_rst_mid");
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
